// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - sequences pipeline register enables/flushes for load-use, memory freeze and branch squash
// Consumes hazard-detection requests and owns the bubble, freeze, squash and delayed EX forward selects.
module pipeline_stall_controller #(
   parameter int MAX_MEM_WAIT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hz_flush,
   input  logic [1:0]  hz_load_useA,
   input  logic [1:0]  hz_load_useB,
   input  logic        branch_taken,
   input  logic        mem_busy,
   output logic        PC_write,
   output logic        IF_ID_write,
   output logic        ID_EXE_write,
   output logic        EXE_MEM_write,
   output logic        MEM_WB_write,
   output logic        IF_ID_flush,
   output logic        ID_EXE_flush,
   output logic [1:0]  fwdA_sel,
   output logic [1:0]  fwdB_sel,
   output logic [1:0]  state,
   output logic [15:0] stall_count,
   output logic        mem_timeout
);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      LU_STALL = 2'b01,
      MEM_WAIT = 2'b10,
      TIMEOUT  = 2'b11
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(MAX_MEM_WAIT - 1);
   localparam logic [4:0] EN_ALL    = 5'b11111;
   localparam logic [4:0] EN_LU     = 5'b00111;

   state_t      state_q, state_d;
   state_t      ret_q, ret_d;
   logic        capa_q, capa_d;
   logic        capb_q, capb_d;
   logic [1:0]  fwda_q, fwda_d;
   logic [1:0]  fwdb_q, fwdb_d;
   logic [7:0]  wait_q, wait_d;
   logic [15:0] stall_q, stall_d;
   logic        timeout_q, timeout_d;

   logic [4:0]  en;
   logic        if_fl, id_fl;
   logic        frz, fwd_load;

   always_comb begin
      state_d   = state_q;
      ret_d     = ret_q;
      capa_d    = capa_q;
      capb_d    = capb_q;
      wait_d    = wait_q;
      timeout_d = timeout_q;
      en        = 5'b00000;
      if_fl     = 1'b0;
      id_fl     = 1'b0;
      frz       = 1'b0;
      fwd_load  = 1'b0;

      case (state_q)
         RUN: begin
            if (mem_busy) begin
               frz     = 1'b1;
               ret_d   = RUN;
               wait_d  = 8'd0;
               state_d = MEM_WAIT;
            end else if (branch_taken) begin
               en    = EN_ALL;
               if_fl = 1'b1;
               id_fl = 1'b1;
            end else if (hz_flush) begin
               en      = EN_LU;
               id_fl   = 1'b1;
               capa_d  = (hz_load_useA == 2'b10);
               capb_d  = (hz_load_useB == 2'b10);
               state_d = LU_STALL;
            end else begin
               en = EN_ALL;
            end
         end
         LU_STALL: begin
            if (mem_busy) begin
               frz     = 1'b1;
               ret_d   = LU_STALL;
               wait_d  = 8'd0;
               state_d = MEM_WAIT;
            end else begin
               en       = EN_ALL;
               fwd_load = 1'b1;
               capa_d   = 1'b0;
               capb_d   = 1'b0;
               state_d  = RUN;
            end
         end
         MEM_WAIT: begin
            if (mem_busy) begin
               frz = 1'b1;
               if (wait_q == WAIT_LAST) begin
                  state_d   = TIMEOUT;
                  timeout_d = 1'b1;
               end else begin
                  wait_d = wait_q + 8'd1;
               end
            end else begin
               en      = EN_ALL;
               state_d = ret_q;
            end
         end
         default: begin
            frz = 1'b1;
         end
      endcase

      // A frozen pipeline keeps the dependent in EX, so its forward select must persist.
      fwda_d = frz ? fwda_q : 2'b00;
      fwdb_d = frz ? fwdb_q : 2'b00;
      if (fwd_load) begin
         fwda_d = capa_q ? 2'b10 : 2'b00;
         fwdb_d = capb_q ? 2'b10 : 2'b00;
      end

      stall_d = stall_q;
      if (!en[4] && stall_q != 16'hFFFF) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RUN;
         ret_q     <= RUN;
         capa_q    <= 1'b0;
         capb_q    <= 1'b0;
         fwda_q    <= 2'b00;
         fwdb_q    <= 2'b00;
         wait_q    <= 8'd0;
         stall_q   <= 16'd0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ret_q     <= ret_d;
         capa_q    <= capa_d;
         capb_q    <= capb_d;
         fwda_q    <= fwda_d;
         fwdb_q    <= fwdb_d;
         wait_q    <= wait_d;
         stall_q   <= stall_d;
         timeout_q <= timeout_d;
      end
   end

   assign {PC_write, IF_ID_write, ID_EXE_write, EXE_MEM_write, MEM_WB_write} = rst ? 5'b00000 : en;
   assign IF_ID_flush  = rst ? 1'b0 : if_fl;
   assign ID_EXE_flush = rst ? 1'b0 : id_fl;
   assign fwdA_sel     = fwda_q;
   assign fwdB_sel     = fwdb_q;
   assign state        = state_q;
   assign stall_count  = stall_q;
   assign mem_timeout  = timeout_q;

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Consumer side of the load-use hazard protocol: takes the stall/flush requests and load-use flags produced in ID, plus branch-taken and data-memory busy, and sequences the write enables and flushes of all pipeline registers. It owns the one-cycle load-use bubble, the multi-cycle memory freeze, the branch squash and the delayed forwarding selects for EX. It sits between the hazard detection logic and the IF/ID, ID/EXE, EXE/MEM and MEM/WB registers.

## Interface
- MAX_MEM_WAIT, 15: consecutive busy cycles in MEM_WAIT before timeout (1..255)
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- hz_flush  input  1  load-use stall request from hazard detection
- hz_load_useA  input  2  2'b10 = operand A depends on load in EX
- hz_load_useB  input  2  2'b10 = operand B depends on load in EX
- branch_taken  input  1  branch resolved taken in EX
- mem_busy  input  1  data memory in MEM not ready this cycle
- PC_write, IF_ID_write, ID_EXE_write, EXE_MEM_write, MEM_WB_write  output  1 each  register enables
- IF_ID_flush, ID_EXE_flush  output  1 each  load a bubble instead of data
- fwdA_sel, fwdB_sel  output  2 each  2'b10 = take operand from MEM/WB, 2'b00 = no override (registered)
- state  output  2  RUN=00, LU_STALL=01, MEM_WAIT=10, TIMEOUT=11
- stall_count  output  16  saturating count of cycles with PC_write=0
- mem_timeout  output  1  sticky memory-timeout flag

## Operation
- Enables and flushes are combinational from state and inputs; state, fwd selects, counters and captured flags are registered.
- RUN, priority high to low:
  - mem_busy=1: all five enables 0, no flush; save return state RUN; next MEM_WAIT. Branch and hazard inputs are ignored (re-presented, as the pipeline is frozen).
  - branch_taken=1: all enables 1, IF_ID_flush=1, ID_EXE_flush=1; stay RUN; hz_flush ignored (dependent is squashed).
  - hz_flush=1: PC_write=0, IF_ID_write=0, ID_EXE_flush=1, ID_EXE_write/EXE_MEM_write/MEM_WB_write=1; capture capA=(hz_load_useA==2'b10), capB=(hz_load_useB==2'b10); next LU_STALL.
  - otherwise all enables 1, flushes 0.
- LU_STALL (exactly one cycle: bubble in EX, load in MEM, dependent in ID):
  - mem_busy=1: freeze as above, save return state LU_STALL, captures held, next MEM_WAIT.
  - else all enables 1; next RUN; fwdA_sel<=capA?2'b10:2'b00, fwdB_sel likewise; captures cleared. hz_flush ignored in this cycle.
- fwd selects are valid for exactly one cycle (the dependent in EX) and return to 00 on the following edge unless reloaded.
- MEM_WAIT: wait counter (8-bit) cleared on entry, +1 per busy cycle.
  - mem_busy=1 and count<MAX_MEM_WAIT-1: all enables 0; stay.
  - mem_busy=1 and count=MAX_MEM_WAIT-1: next TIMEOUT, mem_timeout<=1.
  - mem_busy=0: all enables 1, flushes 0; next = saved return state. fwd selects hold their value across MEM_WAIT.
- TIMEOUT: all enables 0, flushes 0, absorbing until rst.
- stall_count +1 on every edge where PC_write=0 (LU_STALL entry, MEM_WAIT, TIMEOUT), saturates at 16'hFFFF.

## Timing
- Reset (rst=1 at edge): state=RUN, fwdA_sel=fwdB_sel=00, capA=capB=0, stall_count=0, mem_timeout=0, wait counter 0. While rst=1, all enables 0 and flushes 0.
- Load-use penalty: 1 cycle. Cycle N hz_flush -> cycle N+1 LU_STALL -> cycle N+2 fwd select = 10.
- Memory freeze: enables low in the same cycle mem_busy rises; released in the same cycle mem_busy falls.
- Timeout: mem_busy held MAX_MEM_WAIT cycles in MEM_WAIT -> TIMEOUT on the next edge.
- rst mid-stall or mid-wait: aborts immediately, no pending forward survives.

## Test plan
- Load-use A only: hz_flush=1, load_useA=10, load_useB=00 one cycle -> that cycle PC_write=0, ID_EXE_flush=1; next cycle state=01 with all enables 1; following cycle fwdA_sel=10, fwdB_sel=00; then both 00; stall_count=1.
- Branch with simultaneous hz_flush -> IF_ID_flush=ID_EXE_flush=1, PC_write=1, state stays 00, fwd selects stay 00.
- mem_busy high 3 cycles during LU_STALL -> enables 0 for 3 cycles, return to LU_STALL, then fwd selects load 10 as for the unfrozen case; stall_count=4.
- mem_busy stuck high, MAX_MEM_WAIT=15 -> state=11 and mem_timeout=1 after 15 MEM_WAIT cycles, enables 0 until rst; after rst all outputs at reset values.
- Saturation: force >65535 stall cycles -> stall_count holds 16'hFFFF.
- rst asserted in LU_STALL with capA=capB=1 -> next cycle state=00, fwd selects 00, no forward issued.
